// File: rtl/mem_port_sequencer_if.sv
// Bus bundle around the shared memory port sequencer.
//   Requester side : if_req/if_addr/if_ack (fetch), d_req/d_we/d_addr/d_wdata/d_ack (data),
//                    rd_data, err, busy
//   Memory side    : mem_en/mem_we/mem_addr/mem_wdata (request), mem_rdata/mem_ready (reply)
// modport slave  : the sequencer's view (serves requesters, drives the memory request).
// modport master : the environment's view (requesters plus memory model).
interface mem_port_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] rd_data;
    logic              err;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_ack, d_ack, rd_data, err, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_ack, d_ack, rd_data, err, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_sequencer.sv
// Shares one memory port between instruction fetch and data load/store requests.
// Arbitrates (data first, fetch forced after STARVE_LIMIT data grants while fetch
// waits), holds the memory request until mem_ready, returns a single ack pulse and
// flags misaligned addresses or an access that exceeds TIMEOUT_CYC cycles.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - mem_port_sequencer_if.slave: requester handshakes, read data/status,
//          memory request/response
module mem_port_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_sequencer_if.slave   bus
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;     // 1 = data, 0 = fetch
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_q, err_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                grant_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            starve_q  <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        err_d      = err_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        grant_data = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // Fetch only beats a pending data request once it has been starved.
                    grant_data = bus.d_req &&
                                 !(bus.if_req && starve_q == STARVE_W'(STARVE_LIMIT));
                    if (grant_data) begin
                        owner_d = 1'b1;
                        we_d    = bus.d_we;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        // A data grant with fetch pending implies starve_q < limit,
                        // so this increment saturates by construction.
                        if (bus.if_req)
                            starve_d = starve_q + 1'b1;
                    end else begin
                        owner_d  = 1'b0;
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = '0;
                        starve_d = '0;
                    end
                    // Misaligned: skip the memory cycle and answer with err.
                    err_d   = |addr_d[1:0];
                    state_d = err_d ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                tmo_d = tmo_q + 1'b1;
                if (bus.mem_ready) begin
                    if (!we_q)
                        rd_data_d = bus.mem_rdata;
                    state_d = S_RESP;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                tmo_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.if_ack    = (state_q == S_RESP) && !owner_q;
    assign bus.d_ack     = (state_q == S_RESP) &&  owner_q;
    assign bus.err       = (state_q == S_RESP) &&  err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_en    = (state_q == S_ACCESS);
    assign bus.mem_we    = (state_q == S_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_mem_port_sequencer.sv
module tb_mem_port_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_port_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_sequencer #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYC(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    endtask

    initial begin
        int cnt;
        int ng;
        logic got [10];
        logic exp_seq [10];
        logic any_ack;

        idle_inputs();
        rst = 1;
        tick(); tick();
        chk("rst_busy",   bus.busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_acks",   {bus.if_ack, bus.d_ack, bus.err, bus.mem_we}, 0);
        chk("rst_bus",    {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_rdata",  bus.rd_data, 0);
        rst = 0;
        tick();

        // T1: fetch, ready in first ACCESS cycle
        bus.if_req = 1; bus.if_addr = 32'h40;
        tick();
        chk("t1_mem_en",   bus.mem_en, 1);
        chk("t1_mem_we",   bus.mem_we, 0);
        chk("t1_mem_addr", bus.mem_addr, 32'h40);
        chk("t1_busy",     bus.busy, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h8C020004;
        tick();
        chk("t1_if_ack", bus.if_ack, 1);
        chk("t1_d_ack",  bus.d_ack, 0);
        chk("t1_err",    bus.err, 0);
        chk("t1_rdata",  bus.rd_data, 32'h8C020004);
        chk("t1_mem_en_resp", bus.mem_en, 0);
        idle_inputs();
        tick();
        chk("t1_idle", {bus.busy, bus.if_ack}, 0);

        // T2: store, ready on 3rd ACCESS cycle
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hCAFEF00D;
        bus.mem_rdata = 32'h12345678;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_en_we_%0d", i), {bus.mem_en, bus.mem_we}, 2'b11);
            chk($sformatf("t2_addr_%0d", i), bus.mem_addr, 32'h100);
            chk($sformatf("t2_wdata_%0d", i), bus.mem_wdata, 32'hCAFEF00D);
            if (i == 2) bus.mem_ready = 1;
            tick();
        end
        chk("t2_d_ack", {bus.d_ack, bus.if_ack, bus.err}, 3'b100);
        chk("t2_rdata", bus.rd_data, 32'h8C020004);
        idle_inputs();
        tick();

        // T4: misaligned load
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h102;
        tick();
        chk("t4_ack_err", {bus.d_ack, bus.err}, 2'b11);
        chk("t4_mem_en",  bus.mem_en, 0);
        idle_inputs();
        tick();
        chk("t4_busy", bus.busy, 0);

        // T5: timeout, mem_ready stuck low
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        cnt = 0;
        while (bus.mem_en && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("t5_access_cycles", cnt, 15);
        chk("t5_ack_err", {bus.d_ack, bus.err}, 2'b11);
        chk("t5_rdata",   bus.rd_data, 32'h8C020004);
        idle_inputs();
        tick();
        chk("t5_busy", bus.busy, 0);

        // T3: both requests held; fetch forced every 5th grant
        bus.if_req = 1; bus.if_addr = 32'h20;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
        bus.mem_ready = 1; bus.mem_rdata = 32'h0;
        ng = 0;
        for (int c = 0; c < 200 && ng < 10; c++) begin
            tick();
            if (bus.d_ack)       begin got[ng] = 1; ng++; end
            else if (bus.if_ack) begin got[ng] = 0; ng++; end
        end
        idle_inputs();
        chk("t3_grant_count", ng, 10);
        for (int i = 0; i < 10; i++) exp_seq[i] = (i % 5 != 4);
        for (int i = 0; i < ng; i++)
            chk($sformatf("t3_grant_%0d", i), got[i], exp_seq[i]);
        tick();
        tick();
        chk("t3_busy", bus.busy, 0);

        // T6: reset during ACCESS
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        tick();
        chk("t6_in_access", bus.mem_en, 1);
        rst = 1; bus.d_req = 0;
        tick();
        chk("t6_busy",  bus.busy, 0);
        chk("t6_outs",  {bus.mem_en, bus.mem_we, bus.if_ack, bus.d_ack, bus.err}, 0);
        chk("t6_bus",   {bus.mem_addr, bus.mem_wdata}, 0);
        chk("t6_rdata", bus.rd_data, 0);
        rst = 0;
        any_ack = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            any_ack = any_ack | bus.d_ack | bus.if_ack | bus.busy;
        end
        chk("t6_no_ack", any_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
